// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
// Pure declarations: no logic, no latency, no flow control.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam int IE_BIT  = 1;
    localparam int EXL_BIT = 0;
    localparam int MAX_SRC = 32;

endpackage

// File: rtl/int_prio_enc.sv
// Highest-index-wins priority encoder over the masked pending vector.
// Latency: purely combinational.
// Backpressure: none; an empty vector yields id 0 with valid low.
module int_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] id,
    output logic         valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid && vec[i]) begin
                valid = 1'b1;
                id    = W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: sync + edge/level capture, masked priority select, req/ack/eret FSM.
// Latency: irq_in edge to int_req is SYNC_STAGES+2 cycles; ack to exl_set/in_service is 1 cycle.
// Backpressure: a request is held (and re-targeted) until int_ack; no nesting while in service.
module int_ctrl
    import int_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ID_W        = $clog2(NUM_SRC),
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic               status_ie,
    input  logic               status_exl,
    input  logic [NUM_SRC-1:0] pend_clr,
    input  logic               int_ack,
    input  logic               eret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic               exl_set,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_d;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               elig;
    logic               ack_take;

    int_state_t         state_q, state_d;
    logic               int_req_d, exl_set_d, in_service_d;
    logic [ID_W-1:0]    int_id_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq_in;
        end else begin : g_sync
            logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= irq_in;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign irq_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Ack only counts while a request is actually on the wire.
    assign ack_take  = (state_q == REQ) && int_ack && int_req;
    assign ack_clr   = ack_take ? (NUM_SRC'(1) << int_id) : '0;
    assign rise      = irq_s & ~irq_prev;
    // Edge bits: set beats clear. Level bits simply mirror the synchronized line.
    assign pending_d = (edge_mode & ((pending & ~(pend_clr | ack_clr)) | rise))
                     | (~edge_mode & irq_s);

    int_prio_enc #(
        .N (NUM_SRC),
        .W (ID_W)
    ) u_prio (
        .vec   (pending & int_mask),
        .id    (win_id),
        .valid (win_vld)
    );

    assign elig = win_vld && status_ie && !status_exl && !in_service;

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req;
        int_id_d     = int_id;
        exl_set_d    = 1'b0;
        in_service_d = in_service;
        case (state_q)
            IDLE: begin
                if (elig) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                    int_id_d  = win_id;
                end
            end
            REQ: begin
                if (ack_take) begin
                    state_d      = SERVICE;
                    int_req_d    = 1'b0;
                    exl_set_d    = 1'b1;
                    in_service_d = 1'b1;
                end else if (!elig) begin
                    state_d   = IDLE;
                    int_req_d = 1'b0;
                end else begin
                    int_id_d = win_id;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            int_req    <= 1'b0;
            int_id     <= '0;
            exl_set    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev   <= irq_s;
            pending    <= pending_d;
            int_req    <= int_req_d;
            int_id     <= int_id_d;
            exl_set    <= exl_set_d;
            in_service <= in_service_d;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboarded bench for int_ctrl: expected req/exl events queued by stimulus, popped by a monitor.
module tb_int_ctrl;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] irq_in, int_mask, edge_mode, pend_clr, pending;
    logic            status_ie, status_exl, int_ack, eret;
    logic            int_req, exl_set, in_service;
    logic [IDW-1:0]  int_id;

    typedef struct packed {
        logic           kind;   // 0 = request raised/retargeted, 1 = exl_set pulse
        logic [IDW-1:0] id;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    int_ctrl #(.NUM_SRC(NSRC), .ID_W(IDW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .int_mask   (int_mask),
        .edge_mode  (edge_mode),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .pend_clr   (pend_clr),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .exl_set    (exl_set),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic kind, input logic [IDW-1:0] id);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic got_event(input logic kind, input logic [IDW-1:0] id);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d id=%0d want none at %0t", kind, id, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.id !== id) begin
                bad++;
                $display("FAIL event: got kind=%0d id=%0d want kind=%0d id=%0d at %0t",
                         kind, id, e.kind, e.id, $time);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the register updates.
    initial begin
        logic           prev_req;
        logic [IDW-1:0] prev_id;
        prev_req = 1'b0;
        prev_id  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exl_set) got_event(1'b1, int_id);
                if (int_req && (!prev_req || int_id != prev_id)) got_event(1'b0, int_id);
            end
            prev_req = int_req;
            prev_id  = int_id;
        end
    end

    initial begin
        rst_n = 1'b1; irq_in = '0; int_mask = '0; edge_mode = 8'hFD;
        status_ie = 1'b1; status_exl = 1'b0; pend_clr = '0; int_ack = 1'b0; eret = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", int_req, 0);
        chk("rst_id", int_id, 0);
        chk("rst_exl", exl_set, 0);
        chk("rst_pending", pending, 0);
        chk("rst_insvc", in_service, 0);
        step(2);
        rst_n = 1'b1;

        // Edge on src3: request lands exactly 4 cycles after irq_in rises
        int_mask = 8'h08; irq_in = 8'h08; push(0, 3);
        step(3); chk("t1_req_early", int_req, 0);
        step(1); chk("t1_req", int_req, 1); chk("t1_id", int_id, 3); chk("t1_pend", pending, 8'h08);
        int_ack = 1'b1; push(1, 3);
        step(1); int_ack = 1'b0;
        chk("t1_exl", exl_set, 1); chk("t1_insvc", in_service, 1);
        chk("t1_pend_clr", pending, 0); chk("t1_req_off", int_req, 0);
        step(1); chk("t1_exl_pulse", exl_set, 0);
        eret = 1'b1; step(1); eret = 1'b0;
        chk("t1_eret", in_service, 0);
        irq_in = '0; step(3);

        // Level src1 + edge src6: 6 wins, then 1 is served after return
        int_mask = 8'hFF; irq_in = 8'h42; push(0, 6);
        step(4); chk("t2_id6", int_id, 6); chk("t2_req", int_req, 1); chk("t2_pend", pending, 8'h42);
        int_ack = 1'b1; push(1, 6);
        step(1); int_ack = 1'b0; chk("t2_pend_ack", pending, 8'h02);
        step(1);
        eret = 1'b1; push(0, 1);
        step(1); eret = 1'b0; chk("t2_idle_req", int_req, 0); chk("t2_idle_svc", in_service, 0);
        step(1); chk("t2_req1", int_req, 1); chk("t2_id1", int_id, 1);
        int_ack = 1'b1; push(1, 1);
        step(1); int_ack = 1'b0; chk("t2_level_keep", pending, 8'h02);
        irq_in = '0; step(3); chk("t2_level_drop", pending, 0);
        eret = 1'b1; step(1); eret = 1'b0;
        step(2); chk("t2_quiet", int_req, 0);

        // src2 requested, src7 preempts before ack
        irq_in = 8'h04; push(0, 2);
        step(4); chk("t3_req2", int_req, 1); chk("t3_id2", int_id, 2);
        irq_in = 8'h84; push(0, 7);
        step(3); chk("t3_id_hold", int_id, 2);
        step(1); chk("t3_id7", int_id, 7);
        int_ack = 1'b1; push(1, 7);
        step(1); int_ack = 1'b0; chk("t3_pend", pending, 8'h04); chk("t3_insvc", in_service, 1);
        pend_clr = 8'h04;
        step(1); pend_clr = '0; chk("t3_clr", pending, 0);
        irq_in = '0; step(3);
        eret = 1'b1; step(1); eret = 1'b0;
        step(2); chk("t3_quiet", int_req, 0);

        // IE dropped while requesting; stray ack is ignored
        irq_in = 8'h10; push(0, 4);
        step(4); chk("t4_req", int_req, 1);
        status_ie = 1'b0;
        step(1); chk("t4_req_off", int_req, 0); chk("t4_pend", pending, 8'h10);
        int_ack = 1'b1;
        step(1); int_ack = 1'b0;
        chk("t4_no_exl", exl_set, 0); chk("t4_no_svc", in_service, 0); chk("t4_pend_keep", pending, 8'h10);
        pend_clr = 8'h10;
        step(1); pend_clr = '0; chk("t4_clr", pending, 0);
        irq_in = '0; status_ie = 1'b1;
        step(3); chk("t4_quiet", int_req, 0);

        // Set beats clear on src5, then clear alone wins
        int_mask = '0; irq_in = 8'h20;
        step(2); pend_clr = 8'h20;
        step(1); chk("t5_set_wins", pending, 8'h20);
        step(1); pend_clr = '0; chk("t5_clr", pending, 0);
        irq_in = '0; step(3);

        // Reset during SERVICE with pending 0x81
        int_mask = 8'hFF; irq_in = 8'h81; push(0, 7);
        step(4); chk("t6_id7", int_id, 7);
        int_ack = 1'b1; push(1, 7);
        step(1); int_ack = 1'b0; chk("t6_pend_ack", pending, 8'h01);
        irq_in = 8'h01; step(3);
        irq_in = 8'h81; step(4);
        chk("t6_pend81", pending, 8'h81); chk("t6_insvc", in_service, 1);
        irq_in = 8'h02; rst_n = 1'b0;
        #1;
        chk("t6_rst_req", int_req, 0); chk("t6_rst_id", int_id, 0); chk("t6_rst_exl", exl_set, 0);
        chk("t6_rst_pend", pending, 0); chk("t6_rst_svc", in_service, 0);
        step(2);
        rst_n = 1'b1; push(0, 1);
        step(2); chk("t6_post_pend", pending, 0); chk("t6_post_req", int_req, 0);
        step(1); chk("t6_level_repend", pending, 8'h02); chk("t6_req_wait", int_req, 0);
        step(1); chk("t6_req1", int_req, 1); chk("t6_id1", int_id, 1);
        step(2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Parametrised interrupt controller for the CPU core, generalising the existing combinational exception logic.
- Per-source edge/level capture, registered pending bits and a masked priority select.
- Request/acknowledge handshake with the pipeline commit stage, EXL set, and return on ERET.
- Sits between peripheral IRQ lines and the CSR/exception unit.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
ID_W, $clog2(NUM_SRC), width of the interrupt ID
SYNC_STAGES, 2, synchronizer flops per irq input (0 = inputs already synchronous)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_in  in  NUM_SRC  raw interrupt lines
int_mask  in  NUM_SRC  1 = source enabled
edge_mode  in  NUM_SRC  1 = rising-edge source, 0 = level source
status_ie  in  1  global interrupt enable (STATUS[1])
status_exl  in  1  exception level (STATUS[0])
pend_clr  in  NUM_SRC  CSR write-1-to-clear for edge pending bits
int_ack  in  1  pipeline commit takes the interrupt
eret  in  1  exception return committed
int_req  out  1  interrupt request to pipeline
int_id  out  ID_W  ID of requested or in-service source
exl_set  out  1  one-cycle pulse: set STATUS.EXL
pending  out  NUM_SRC  raw pending bits (CSR readable)
in_service  out  1  handler active

Behaviour:
- Reset (async, rst_n=0): synchronizers, pending, int_req, int_id, exl_set and in_service all 0; state IDLE.
- Sync: irq_s = irq_in after SYNC_STAGES flops. The edge detector keeps irq_s from the previous cycle.
- Edge source:
  - pending[i] sets on irq_s rising.
  - It clears on pend_clr[i], or on int_ack when int_id==i.
  - If set and clear happen in the same cycle, set wins.
- Level source: pending[i] = registered irq_s[i]. pend_clr and ack have no effect on it.
- Masked vector: act = pending & int_mask.
- Priority: highest index wins. The encoder is purely combinational; act==0 gives win_id 0 and valid 0.
- Eligibility: elig = valid & status_ie & ~status_exl & ~in_service.
- State IDLE:
  - If elig, go to REQ next cycle with int_req=1 and int_id=win_id, both registered.
- State REQ:
  - int_id re-tracks win_id every cycle, so a higher-priority arrival preempts before ack.
  - If elig drops, go to IDLE with int_req=0 next cycle.
  - If int_ack=1 while int_req=1, go to SERVICE: int_req 0, exl_set=1 for exactly one cycle, in_service 1. int_id freezes at the value sampled with ack.
  - int_ack while int_req=0 is ignored.
- State SERVICE:
  - No new request, even if the handler clears EXL or sets IE (no nesting).
  - eret=1 gives in_service 0 and a return to IDLE next cycle. The earliest new int_req is 1 cycle after that.
- eret outside SERVICE is ignored.
- If ack and eret arrive in the same cycle in REQ, ack is taken and eret ignored.
- Latency: an edge on irq_in raises int_req SYNC_STAGES+2 cycles later.
- Reset mid-operation: everything returns to reset values immediately, and in-flight pending edges are lost.

Decomposition:
- Shared package int_pkg:
  - state enum {IDLE, REQ, SERVICE}, 2 bits
  - STATUS bit index constants IE_BIT=1, EXL_BIT=0
  - MAX_SRC=32
- One sub-module int_prio_enc: param N, W; input vec[N]; outputs id[W], valid. Generated loop, highest index first.

Test Plan:
- Edge on src3, mask=0x08, ie=1, exl=0, SYNC_STAGES=2 -> int_req=1 at cycle 4, int_id=3. Ack gives exl_set pulse, in_service=1, pending[3]=0.
- Level src1 and edge src6 both pending, mask=0xFF -> int_id=6. After ack and eret, src1 is still asserted -> int_req with int_id=1, one cycle after the return to IDLE.
- src2 in REQ, then src7 edge arrives before ack -> int_id changes to 7. Ack clears only pending[7]; pending[2] stays 1.
- In REQ, drive status_ie=0 -> int_req=0 next cycle, pending unchanged. Ack while int_req=0 -> no exl_set.
- pend_clr[5]=1 in the same cycle as a src5 rising edge -> pending[5]=1. pend_clr alone one cycle later -> 0.
- Assert rst_n=0 during SERVICE with pending=0x81 -> all outputs 0 asynchronously. After release, int_req stays 0 until new edges arrive; level lines re-pend.
